// File: rtl/shift_operand_decoder.sv
// shift_operand_decoder
// Decodes the operand2 field of ARM7TDMI data-processing instructions into
// barrel-shifter controls (opcode, amount, Rm / immediate). Register-specified
// shifts take an extra register-file read cycle to fetch Rs.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready instruction handshake (in_ready only in IDLE, rst low)
//   instr             instruction word (uses [25] and [11:0])
//   rs_rd_en/rs_addr  one-cycle Rs read strobe and Rs index
//   rs_data           Rs value, valid the cycle after rs_rd_en
//   out_valid/ready   decoded operand handshake
//   out_opcode        000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX
//   out_shift_amount  shift / rotate count
//   out_rm            Rm index (0 for immediates)
//   out_use_imm       operand is out_imm
//   out_imm           zero-extended imm8

module shift_operand_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        rs_rd_en,
    output logic [3:0]  rs_addr,
    input  logic [31:0] rs_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_opcode,
    output logic [7:0]  out_shift_amount,
    output logic [3:0]  out_rm,
    output logic        out_use_imm,
    output logic [31:0] out_imm
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned AMT_W  = 8;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [OP_W-1:0] OP_LSL = 3'b000;
    localparam logic [OP_W-1:0] OP_LSR = 3'b001;
    localparam logic [OP_W-1:0] OP_ASR = 3'b010;
    localparam logic [OP_W-1:0] OP_ROR = 3'b011;
    localparam logic [OP_W-1:0] OP_RRX = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RS_REQ  = 2'd1,
        S_RS_WAIT = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                rs_rd_en_d;
    logic [REG_W-1:0]    rs_addr_d;
    logic                out_valid_d;
    logic [OP_W-1:0]     opcode_d;
    logic [AMT_W-1:0]    amount_d;
    logic [REG_W-1:0]    rm_d;
    logic                use_imm_d;
    logic [DATA_W-1:0]   imm_d;

    logic [4:0]          amt5;
    logic [1:0]          shift_type;

    // Bits of the instruction and Rs value that the decoder does not look at.
    logic                unused_bits;
    assign unused_bits = ^{instr[31:26], instr[24:12], rs_data[31:8]};

    assign amt5       = instr[11:7];
    assign shift_type = instr[6:5];

    // Ready is gated by rst so no handshake can complete on a reset edge.
    assign in_ready = (state_q == S_IDLE) && !rst;

    // Next-state and next-output decode.
    always_comb begin
        state_d   = state_q;
        rs_addr_d = rs_addr;
        opcode_d  = out_opcode;
        amount_d  = out_shift_amount;
        rm_d      = out_rm;
        use_imm_d = out_use_imm;
        imm_d     = out_imm;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rs_addr_d = instr[11:8];
                    if (instr[25]) begin
                        // 8-bit immediate rotated right by twice the 4-bit field
                        opcode_d  = OP_ROR;
                        amount_d  = AMT_W'({instr[11:8], 1'b0});
                        rm_d      = '0;
                        use_imm_d = 1'b1;
                        imm_d     = DATA_W'(instr[7:0]);
                        state_d   = S_OUT;
                    end else if (!instr[4]) begin
                        rm_d      = instr[3:0];
                        use_imm_d = 1'b0;
                        imm_d     = '0;
                        state_d   = S_OUT;
                        // A zero count encodes #32 for LSR/ASR and RRX for ROR
                        case (shift_type)
                            2'b00: begin
                                opcode_d = OP_LSL;
                                amount_d = AMT_W'(amt5);
                            end
                            2'b01: begin
                                opcode_d = OP_LSR;
                                amount_d = (amt5 == 5'd0) ? AMT_W'(32) : AMT_W'(amt5);
                            end
                            2'b10: begin
                                opcode_d = OP_ASR;
                                amount_d = (amt5 == 5'd0) ? AMT_W'(32) : AMT_W'(amt5);
                            end
                            default: begin
                                opcode_d = (amt5 == 5'd0) ? OP_RRX : OP_ROR;
                                amount_d = (amt5 == 5'd0) ? AMT_W'(1) : AMT_W'(amt5);
                            end
                        endcase
                    end else begin
                        // Register shift: amount arrives later from Rs
                        opcode_d  = OP_W'(shift_type);
                        amount_d  = '0;
                        rm_d      = instr[3:0];
                        use_imm_d = 1'b0;
                        imm_d     = '0;
                        state_d   = S_RS_REQ;
                    end
                end
            end
            S_RS_REQ: begin
                state_d = S_RS_WAIT;
            end
            S_RS_WAIT: begin
                amount_d = rs_data[7:0];
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rs_rd_en_d  = (state_d == S_RS_REQ);
        out_valid_d = (state_d == S_OUT);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            rs_rd_en         <= 1'b0;
            rs_addr          <= '0;
            out_valid        <= 1'b0;
            out_opcode       <= '0;
            out_shift_amount <= '0;
            out_rm           <= '0;
            out_use_imm      <= 1'b0;
            out_imm          <= '0;
        end else begin
            state_q          <= state_d;
            rs_rd_en         <= rs_rd_en_d;
            rs_addr          <= rs_addr_d;
            out_valid        <= out_valid_d;
            out_opcode       <= opcode_d;
            out_shift_amount <= amount_d;
            out_rm           <= rm_d;
            out_use_imm      <= use_imm_d;
            out_imm          <= imm_d;
        end
    end

endmodule

// File: tb/tb_shift_operand_decoder.sv
// Testbench for shift_operand_decoder: directed vector table, random
// instructions against a reference model, backpressure and mid-flight reset.

module tb_shift_operand_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        rs_rd_en;
    logic [3:0]  rs_addr;
    logic [31:0] rs_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_opcode;
    logic [7:0]  out_shift_amount;
    logic [3:0]  out_rm;
    logic        out_use_imm;
    logic [31:0] out_imm;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs_data;
        logic [2:0]  op;
        logic [7:0]  amt;
        logic [3:0]  rm;
        logic        use_imm;
        logic [31:0] imm;
        logic        is_reg;
    } vec_t;

    shift_operand_decoder dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .instr            (instr),
        .rs_rd_en         (rs_rd_en),
        .rs_addr          (rs_addr),
        .rs_data          (rs_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_opcode       (out_opcode),
        .out_shift_amount (out_shift_amount),
        .out_rm           (out_rm),
        .out_use_imm      (out_use_imm),
        .out_imm          (out_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model built directly from the operand2 encoding rules.
    function automatic vec_t model(input logic [31:0] ins, input logic [31:0] rsd);
        vec_t v;
        int   n;
        int   typ;
        v.instr   = ins;
        v.rs_data = rsd;
        v.is_reg  = 1'b0;
        v.imm     = 32'd0;
        v.use_imm = 1'b0;
        if (ins[25]) begin
            v.op      = 3'd3;
            v.amt     = 8'(2 * int'(ins[11:8]));
            v.rm      = 4'd0;
            v.use_imm = 1'b1;
            v.imm     = 32'(ins[7:0]);
        end else begin
            v.rm = ins[3:0];
            typ  = int'(ins[6:5]);
            if (ins[4]) begin
                v.is_reg = 1'b1;
                v.op     = 3'(typ);
                v.amt    = rsd[7:0];
            end else begin
                n = int'(ins[11:7]);
                if (typ == 0) begin
                    v.op  = 3'd0;
                    v.amt = 8'(n);
                end else if (typ == 3) begin
                    v.op  = (n == 0) ? 3'd4 : 3'd3;
                    v.amt = (n == 0) ? 8'd1 : 8'(n);
                end else begin
                    v.op  = 3'(typ);
                    v.amt = (n == 0) ? 8'd32 : 8'(n);
                end
            end
        end
        return v;
    endfunction

    // Offer one instruction, follow it to the output handshake and check it.
    task automatic do_op(input vec_t v, input string name);
        int   lat;
        logic rd_ok;
        @(negedge clk);
        in_valid = 1'b1;
        instr    = v.instr;
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        instr    = $urandom();
        lat      = 0;
        rd_ok    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rs_rd_en !== (v.is_reg && k == 1)) rd_ok = 1'b0;
            if (out_valid) begin
                lat = k;
                break;
            end
            if (in_ready) rd_ok = 1'b0;
            rs_data = (v.is_reg && k == 2) ? v.rs_data : $urandom();
        end
        chk({name, " latency"}, 32'(lat), v.is_reg ? 32'd3 : 32'd1);
        chk({name, " rd_strobe"}, 32'(rd_ok), 32'd1);
        chk({name, " opcode"}, 32'(out_opcode), 32'(v.op));
        chk({name, " amount"}, 32'(out_shift_amount), 32'(v.amt));
        chk({name, " rm"}, 32'(out_rm), 32'(v.rm));
        chk({name, " use_imm"}, 32'(out_use_imm), 32'(v.use_imm));
        chk({name, " imm"}, out_imm, v.imm);
        if (v.is_reg) chk({name, " rs_addr"}, 32'(rs_addr), 32'(v.instr[11:8]));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, " valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, " ready_back"}, 32'(in_ready), 32'd1);
    endtask

    vec_t tbl [7];

    initial begin
        vec_t v;
        logic [2:0]  h_op;
        logic [7:0]  h_amt;
        logic [31:0] ins;

        tbl[0] = '{32'hE0810182, 32'h0, 3'd0, 8'd3,    4'd2, 1'b0, 32'h0,  1'b0};
        tbl[1] = '{32'hE0810022, 32'h0, 3'd1, 8'd32,   4'd2, 1'b0, 32'h0,  1'b0};
        tbl[2] = '{32'hE0810042, 32'h0, 3'd2, 8'd32,   4'd2, 1'b0, 32'h0,  1'b0};
        tbl[3] = '{32'hE0810062, 32'h0, 3'd4, 8'd1,    4'd2, 1'b0, 32'h0,  1'b0};
        tbl[4] = '{32'hE0810002, 32'h0, 3'd0, 8'd0,    4'd2, 1'b0, 32'h0,  1'b0};
        tbl[5] = '{32'hE3A004FF, 32'h0, 3'd3, 8'd8,    4'd0, 1'b1, 32'hFF, 1'b0};
        tbl[6] = '{32'hE0810352, 32'h121, 3'd2, 8'h21, 4'd2, 1'b0, 32'h0,  1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'd0;
        rs_data   = 32'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst rs_rd_en", 32'(rs_rd_en), 32'd0);
        chk("rst fields", {out_imm[15:0], out_shift_amount, 1'b0, out_opcode,
                           out_rm, rs_addr[2:0], out_use_imm}, 32'd0);
        chk("rst imm_hi", 32'(out_imm[31:16]), 32'd0);
        chk("rst rs_addr", 32'(rs_addr), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) do_op(tbl[i], $sformatf("vec%0d", i));

        // Random instructions against the reference model
        for (int i = 0; i < 40; i++) begin
            v = model($urandom(), $urandom());
            do_op(v, $sformatf("rnd%0d", i));
        end

        // Backpressure: second instruction must wait for the out handshake
        @(negedge clk);
        in_valid = 1'b1;
        instr    = 32'hE0810182;
        @(posedge clk);
        #1;
        instr = 32'hE3A004FF;
        @(negedge clk);
        chk("bp first valid", 32'(out_valid), 32'd1);
        h_op  = out_opcode;
        h_amt = out_shift_amount;
        chk("bp first opcode", 32'(h_op), 32'd0);
        chk("bp first amount", 32'(h_amt), 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold in_ready", 32'(in_ready), 32'd0);
            chk("bp hold fields", {out_opcode, out_shift_amount, out_rm, out_use_imm},
                {h_op, h_amt, 4'd2, 1'b0});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        chk("bp release valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp second valid", 32'(out_valid), 32'd1);
        chk("bp second opcode", 32'(out_opcode), 32'd3);
        chk("bp second amount", 32'(out_shift_amount), 32'd8);
        chk("bp second imm", out_imm, 32'hFF);
        chk("bp second use_imm", 32'(out_use_imm), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during RS_WAIT discards the pending register shift
        @(negedge clk);
        in_valid = 1'b1;
        instr    = 32'hE0810352;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rw rs_rd_en", 32'(rs_rd_en), 32'd1);
        @(negedge clk);
        rst     = 1'b1;
        rs_data = 32'h121;
        @(negedge clk);
        chk("rw out_valid", 32'(out_valid), 32'd0);
        chk("rw rs_rd_en after", 32'(rs_rd_en), 32'd0);
        chk("rw in_ready in rst", 32'(in_ready), 32'd0);
        chk("rw fields", {out_opcode, out_shift_amount, out_rm, rs_addr, out_use_imm},
            32'd0);
        chk("rw imm", out_imm, 32'd0);
        rst = 1'b0;
        #1;
        chk("rw in_ready idle", 32'(in_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rw stays idle", 32'(out_valid), 32'd0);
        end
        do_op(tbl[0], "post_rst");

        // Register shift with amounts of 0 and >= 32 passed through unchanged
        ins = 32'hE0810372;
        do_op(model(ins, 32'hFFFFFF00), "reg_zero");
        do_op(model(32'hE0810312, 32'h000000C8), "reg_big");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_operand_decoder.md
# shift_operand_decoder

Decodes the shifter-operand field (operand2) of ARM7TDMI data-processing instructions into the control inputs of the barrel shifter: shift opcode, shift amount, Rm index or immediate value. For register-specified shifts it runs the extra register-file read cycle for Rs. It sits between the instruction decode stage and the barrel shifter, with valid/ready handshakes on both sides.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word offered.
- in_ready  out  1  block can accept; high only in IDLE with rst low.
- instr  in  32  instruction word; only [25] and [11:0] are used.
- rs_rd_en  out  1  one-cycle register-file read strobe for Rs.
- rs_addr  out  4  Rs index (instr[11:8]); held from acceptance until return to IDLE.
- rs_data  in  32  Rs value, valid on the cycle after rs_rd_en.
- out_valid  out  1  decoded operand available.
- out_ready  in  1  barrel shifter consumes it.
- out_opcode  out  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX.
- out_shift_amount  out  8  shift or rotate count.
- out_rm  out  4  Rm index (instr[3:0]); 0 when the operand is an immediate.
- out_use_imm  out  1  1 means the shifter operand is out_imm.
- out_imm  out  32  zero-extended imm8 (instr[7:0]) when instr[25]=1, else 0.

## Operation
- Reset (rst=1 on a clock edge): state becomes IDLE. out_valid, rs_rd_en, out_use_imm are 0. out_opcode, out_shift_amount, out_rm, out_imm, rs_addr are all 0. in_ready is 0 while rst is high.
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, the instruction is accepted and the next state is chosen by form:
    - Immediate (instr[25]=1) or immediate shift (instr[25]=0, instr[4]=0): outputs are latched and the next state is OUT.
    - Register shift (instr[25]=0, instr[4]=1): rs_addr and the pending opcode/Rm are latched, and the next state is RS_REQ.
  - RS_REQ: rs_rd_en=1 for exactly this cycle. The next state is RS_WAIT.
  - RS_WAIT: rs_data is sampled; out_shift_amount=rs_data[7:0]. The next state is OUT.
  - OUT: out_valid=1 and all out_* are held stable. When out_ready=1, the next state is IDLE.
- Immediate form:
  - out_opcode=011 (ROR), out_shift_amount = 2*instr[11:8] (range 0..30), out_use_imm=1.
  - out_imm = {24'b0, instr[7:0]}.
- Immediate shift form: type = instr[6:5], amt5 = instr[11:7], out_rm = instr[3:0].
  - type 00: LSL, amount = amt5 (LSL #0 gives amount 0).
  - type 01: LSR, amount = amt5, except amt5=0 gives 32.
  - type 10: ASR, amount = amt5, except amt5=0 gives 32.
  - type 11: ROR with amount = amt5; amt5=0 gives opcode 100 (RRX) with amount 1.
- Register shift form:
  - Opcode comes from type (00..11 map to 000..011); RRX is never produced in this form.
  - Amount is rs_data[7:0] unmodified (0 and values of 32 or more are passed through).
  - instr[7] is not checked; excluding multiply/extension encodings is the upstream decoder's job.
- Only one instruction is in flight. in_valid is ignored outside IDLE.

## Timing
- Acceptance cycle is T (in_valid and in_ready both high at the edge).
- Immediate forms: out_valid=1 from T+1.
- Register shift:
  - rs_rd_en=1 during T+1 only.
  - rs_data is sampled at the T+2 edge.
  - out_valid=1 from T+3.
- Back-to-back: after the out handshake at edge E, in_ready=1 in cycle E+1. Maximum throughput is one immediate operand per 2 cycles.
- rst high in any state returns the block to IDLE at that edge:
  - Any pending operand is discarded.
  - out_valid and rs_rd_en are 0 in the following cycle.
  - No handshake completes on that edge.
- out_valid never drops without out_ready.

## Test plan
- Immediate shift: instr 0xE0810182 (LSL #3, Rm=2) accepted at T -> at T+1 out_valid=1, opcode 000, amount 3, rm 2, use_imm 0; rs_rd_en never asserted.
- Special cases:
  - 0xE0810022 -> opcode 001, amount 32.
  - 0xE0810042 -> opcode 010, amount 32.
  - 0xE0810062 -> opcode 100, amount 1.
  - 0xE0810002 -> opcode 000, amount 0.
- Immediate: 0xE3A004FF -> opcode 011, amount 8, use_imm 1, imm 0x000000FF, rm 0.
- Register shift: 0xE0810352 (ASR by r3, Rm=2), rs_data=0x00000121 during T+2 -> rs_addr 3; rs_rd_en high in T+1 only; at T+3 opcode 010, amount 0x21, rm 2.
- Backpressure: hold out_ready=0 for 5 cycles in OUT while in_valid=1 with a new instr -> outputs stable, in_ready 0, second instr not accepted. Release out_ready -> in_ready 1 next cycle and the second instr is accepted.
- Reset mid-operation: rst=1 for one cycle during RS_WAIT -> next cycle state is IDLE, out_valid 0, rs_rd_en 0, all outputs 0. A subsequent 0xE0810182 decodes correctly.
